// File: rtl/sum_seg7_display.sv
// Converts a 6-bit binary sum to two BCD digits with a sequential double-dabble engine
// and multiplexes them onto the two rightmost 7-segment digits of the board.
module sum_seg7_display #(
   parameter int unsigned SCAN_DIV = 100000,
   parameter int unsigned VAL_W    = 6
) (
   input  logic             CLK100MHZ,
   input  logic             rst,
   input  logic             load,
   input  logic [VAL_W-1:0] value,
   output logic             busy,
   output logic [7:0]       AN,
   output logic [6:0]       SEG,
   output logic             DP
);

   localparam int unsigned SrW  = 8 + VAL_W;
   localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [0:0] {StIdle, StConv} state_e;

   state_e          state_q, state_d;
   logic [SrW-1:0]  shift_q, shift_d;
   logic [3:0]      iter_q, iter_d;
   logic            busy_q, busy_d;
   logic [3:0]      tens_q, tens_d;
   logic [3:0]      ones_q, ones_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sel_q, sel_d;
   logic [7:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;

   logic [3:0]      tens_adj, ones_adj;
   logic [SrW-1:0]  step;

   function automatic logic [6:0] enc(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // One double-dabble iteration: add-3 correction on both nibbles, then shift left.
   always_comb begin
      tens_adj = shift_q[SrW-1 -: 4];
      ones_adj = shift_q[SrW-5 -: 4];
      if (tens_adj >= 4'd5) tens_adj = tens_adj + 4'd3;
      if (ones_adj >= 4'd5) ones_adj = ones_adj + 4'd3;
      step = {tens_adj[2:0], ones_adj, shift_q[VAL_W-1:0], 1'b0};
   end

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      iter_d  = iter_q;
      busy_d  = busy_q;
      tens_d  = tens_q;
      ones_d  = ones_q;
      unique case (state_q)
         StIdle: begin
            if (load) begin
               shift_d = {8'd0, value};
               iter_d  = 4'd0;
               busy_d  = 1'b1;
               state_d = StConv;
            end
         end
         StConv: begin
            shift_d = step;
            iter_d  = iter_q + 4'd1;
            if (iter_q == 4'(VAL_W - 1)) begin
               tens_d  = step[SrW-1 -: 4];
               ones_d  = step[SrW-5 -: 4];
               busy_d  = 1'b0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q + CntW'(1);
      sel_d = sel_q;
      if (cnt_q == CntW'(SCAN_DIV - 1)) begin
         cnt_d = '0;
         sel_d = ~sel_q;
      end
      an_d  = 8'hFE;
      seg_d = enc(ones_q);
      if (sel_q) begin
         // Leading-zero blank keeps the slot length so brightness stays even.
         if (tens_q == 4'd0) begin
            an_d  = 8'hFF;
            seg_d = 7'h7F;
         end else begin
            an_d  = 8'hFD;
            seg_d = enc(tens_q);
         end
      end
   end

   always_ff @(posedge CLK100MHZ or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         shift_q <= '0;
         iter_q  <= '0;
         busy_q  <= 1'b0;
         tens_q  <= '0;
         ones_q  <= '0;
         cnt_q   <= '0;
         sel_q   <= 1'b0;
         an_q    <= 8'hFE;
         seg_q   <= 7'h40;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         iter_q  <= iter_d;
         busy_q  <= busy_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
      end
   end

   assign busy = busy_q;
   assign AN   = an_q;
   assign SEG  = seg_q;
   assign DP   = 1'b1;

endmodule
